// File: rtl/dynamixel_pkg.sv
// Shared types for the Dynamixel protocol-1 status receiver.
//   fail_code_t : result code reported with each completed status packet
//   rx_state_t  : parser FSM states
//   bit_state_t : byte receiver bit-timing states
//   HDR_BYTE    : header/preamble byte value
package dynamixel_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    FcOk       = 2'b00,
    FcTimeout  = 2'b01,
    FcChecksum = 2'b10,
    FcFormat   = 2'b11
  } fail_code_t;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StHdr1  = 4'd1,
    StHdr2  = 4'd2,
    StId    = 4'd3,
    StLen   = 4'd4,
    StErr   = 4'd5,
    StParam = 4'd6,
    StChk   = 4'd7,
    StFin   = 4'd8
  } rx_state_t;

  typedef enum logic [1:0] {
    BitIdle  = 2'd0,
    BitStart = 2'd1,
    BitData  = 2'd2,
    BitStop  = 2'd3
  } bit_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver for the half-duplex Dynamixel bus.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   rxd          : raw asynchronous bus line, idle high
//   byte_valid   : 1-cycle pulse, data holds a byte with a good stop bit
//   frame_err    : 1-cycle pulse, stop bit sampled low
//   data         : last received byte
module uart_rx_byte
  import dynamixel_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 869
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] data
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  sync_q;
  logic        prev_q;
  bit_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx;

  assign rx = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      BitIdle: begin
        if (prev_q && !rx) begin
          state_d = BitStart;
          cnt_d   = '0;
        end
      end
      BitStart: begin
        // Mid-start-bit check rejects short glitches on the line.
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? BitIdle : BitData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BitData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = BitStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BitStop: begin
        if (cnt_q == BitLast) begin
          valid_d = rx;
          ferr_d  = !rx;
          state_d = BitIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = BitIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Synchronizer resets to the idle level so no false start edge appears.
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= BitIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      prev_q  <= rx;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
  assign data       = shift_q;

endmodule

// File: rtl/dynamixel_status_rx.sv
// Dynamixel protocol-1 status packet receiver and parser.
// Ports:
//   clk, reset_n  : 50 MHz clock, asynchronous active-low reset
//   arm           : 1-cycle pulse, clear results and start listening
//   rxd           : raw bus line, idle high
//   busy          : high from arm until the result is reported
//   done          : 1-cycle pulse when a packet is accepted or rejected
//   fail_code     : 00 OK, 01 TIMEOUT, 10 CHECKSUM, 11 FORMAT
//   status_id/len/err : header fields of the last packet
//   status_params : param k in bits [8k+7:8k], unused bytes 0
module dynamixel_status_rx
  import dynamixel_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 869,
  parameter int unsigned MAX_PARAMS   = 4,
  parameter int unsigned TIMEOUT_CYC  = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    rxd,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              fail_code,
  output logic [7:0]              status_id,
  output logic [7:0]              status_len,
  output logic [7:0]              status_err,
  output logic [8*MAX_PARAMS-1:0] status_params
);

  localparam logic [7:0]  LenMax  = 8'(MAX_PARAMS + 2);
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYC - 1);

  logic       byte_valid, frame_err;
  logic [7:0] rx_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .data      (rx_data)
  );

  rx_state_t               state_q, state_d;
  fail_code_t              fail_q, fail_d;
  logic [7:0]              id_q, id_d, len_q, len_d, err_q, err_d;
  logic [8*MAX_PARAMS-1:0] params_q, params_d;
  logic [7:0]              sum_q, sum_d, cnt_q, cnt_d;
  logic [31:0]             tmo_q, tmo_d;
  logic                    past_hdr;

  assign busy     = !(state_q inside {StIdle, StFin});
  assign past_hdr = state_q inside {StId, StLen, StErr, StParam, StChk};

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    id_d     = id_q;
    len_d    = len_q;
    err_d    = err_q;
    params_d = params_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    tmo_d    = busy ? tmo_q + 32'd1 : tmo_q;

    if (arm) begin
      // Arm overrides everything, including a pending timeout or result.
      state_d  = StHdr1;
      fail_d   = FcOk;
      id_d     = '0;
      len_d    = '0;
      err_d    = '0;
      params_d = '0;
      sum_d    = '0;
      cnt_d    = '0;
      tmo_d    = '0;
    end else if (busy && tmo_q == TmoLast) begin
      state_d = StFin;
      fail_d  = FcTimeout;
    end else if (past_hdr && frame_err) begin
      // Framing errors before the header are treated as turnaround noise.
      state_d = StFin;
      fail_d  = FcFormat;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHdr1: if (byte_valid && rx_data == HDR_BYTE) state_d = StHdr2;
        StHdr2: if (byte_valid) state_d = (rx_data == HDR_BYTE) ? StId : StHdr1;
        StId: begin
          if (byte_valid && rx_data != HDR_BYTE) begin
            id_d    = rx_data;
            sum_d   = sum_q + rx_data;
            state_d = StLen;
          end
        end
        StLen: begin
          if (byte_valid) begin
            len_d = rx_data;
            sum_d = sum_q + rx_data;
            if (rx_data < 8'd2 || rx_data > LenMax) begin
              state_d = StFin;
              fail_d  = FcFormat;
            end else begin
              state_d = StErr;
            end
          end
        end
        StErr: begin
          if (byte_valid) begin
            err_d   = rx_data;
            sum_d   = sum_q + rx_data;
            state_d = (len_q == 8'd2) ? StChk : StParam;
          end
        end
        StParam: begin
          if (byte_valid) begin
            for (int k = 0; k < MAX_PARAMS; k++) begin
              if (cnt_q == 8'(k)) params_d[8*k +: 8] = rx_data;
            end
            sum_d = sum_q + rx_data;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == len_q - 8'd2) state_d = StChk;
          end
        end
        StChk: begin
          if (byte_valid) begin
            state_d = StFin;
            fail_d  = (rx_data == ~sum_q) ? FcOk : FcChecksum;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      fail_q   <= FcOk;
      id_q     <= '0;
      len_q    <= '0;
      err_q    <= '0;
      params_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      id_q     <= id_d;
      len_q    <= len_d;
      err_q    <= err_d;
      params_q <= params_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  // An arm landing on the result cycle swallows the pulse.
  assign done          = (state_q == StFin) && !arm;
  assign fail_code     = fail_q;
  assign status_id     = id_q;
  assign status_len    = len_q;
  assign status_err    = err_q;
  assign status_params = params_q;

endmodule
